// File: rtl/scr1_tcm_port_ctrl.sv
// Initiator-side controller for the dual-port TCM.
// Port A carries instruction fetches (read-only) and port B carries data
// loads/stores. Every request is accepted in the cycle it is presented and
// answered exactly one cycle later, matching the array's synchronous read.
module scr1_tcm_port_ctrl #(
  parameter int SCR1_WIDTH  = 32,
  parameter int SCR1_SIZE   = 32'h00010000,
  parameter int SCR1_NBYTES = SCR1_WIDTH/8,
  localparam int AW         = $clog2(SCR1_SIZE) - 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // instruction interface
  input  logic                   imem_req,
  input  logic [31:0]            imem_addr,
  output logic                   imem_req_ack,
  output logic [SCR1_WIDTH-1:0]  imem_rdata,
  output logic [1:0]             imem_resp,
  // data interface
  input  logic                   dmem_req,
  input  logic                   dmem_cmd,
  input  logic [1:0]             dmem_width,
  input  logic [31:0]            dmem_addr,
  input  logic [SCR1_WIDTH-1:0]  dmem_wdata,
  output logic                   dmem_req_ack,
  output logic [SCR1_WIDTH-1:0]  dmem_rdata,
  output logic [1:0]             dmem_resp,
  // TCM port A
  output logic                   rena,
  output logic [AW-1:0]          addra,
  input  logic [SCR1_WIDTH-1:0]  qa,
  // TCM port B
  output logic                   renb,
  output logic                   wenb,
  output logic [SCR1_NBYTES-1:0] webb,
  output logic [AW-1:0]          addrb,
  output logic [SCR1_WIDTH-1:0]  datab,
  input  logic [SCR1_WIDTH-1:0]  qb
);

  typedef enum logic [1:0] {
    RESP_IDLE = 2'b00,
    RESP_OK   = 2'b01,
    RESP_ERR  = 2'b10
  } resp_e;

  resp_e                  ista;
  resp_e                  dsta;
  logic                   drd_q;   // response in flight is a successful load
  logic [1:0]             doff_q;
  logic [1:0]             dwid_q;

  logic                   ifetch_ok;
  logic                   dmisal;
  logic [1:0]             doff;
  logic [SCR1_NBYTES-1:0] dmask;
  logic [SCR1_WIDTH-1:0]  qsh;

  // Range decode happens upstream, so the address bits above the TCM are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imem_addr[31:AW+2], dmem_addr[31:AW+2]};

  // ---------------- fetch side ----------------
  assign imem_req_ack = imem_req;
  assign ifetch_ok    = imem_req & (imem_addr[1:0] == 2'b00);
  assign rena         = ifetch_ok;
  assign addra        = imem_addr[AW+1:2];
  assign imem_resp    = ista;
  // qa is only meaningful in the cycle after an aligned fetch
  assign imem_rdata   = (ista == RESP_OK) ? qa : '0;

  // Fetch response stage: reloaded every cycle from the current request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ista <= RESP_IDLE;
    else if (!imem_req)      ista <= RESP_IDLE;
    else if (ifetch_ok)      ista <= RESP_OK;
    else                     ista <= RESP_ERR;
  end

  // ---------------- data side ----------------
  assign dmem_req_ack = dmem_req;
  assign doff         = dmem_addr[1:0];

  // Misalignment check and byte-lane pattern for the requested width.
  always_comb begin
    dmisal = 1'b0;
    dmask  = '0;
    case (dmem_width)
      2'b00: dmask = SCR1_NBYTES'(4'b0001) << doff;
      2'b01: begin
        dmisal = doff[0];
        dmask  = SCR1_NBYTES'(4'b0011) << doff;
      end
      2'b10: begin
        dmisal = (doff != 2'b00);
        dmask  = '1;
      end
      default: dmisal = 1'b1;
    endcase
  end

  assign renb  = dmem_req & ~dmem_cmd & ~dmisal;
  assign wenb  = dmem_req &  dmem_cmd & ~dmisal;
  assign addrb = dmem_addr[AW+1:2];
  // store data moves up to its byte lane; lanes outside webb are don't-care
  assign datab = dmem_wdata << {doff, 3'b000};
  // load data comes back down to bit 0 using the offset saved at acceptance
  assign qsh   = qb >> {doff_q, 3'b000};

  // Per-lane write strobe and read-data zero-extension.
  for (genvar i = 0; i < SCR1_NBYTES; i++) begin : g_lane
    logic keep;
    if (i == 0)      begin : g_b0 assign keep = 1'b1;                  end
    else if (i == 1) begin : g_b1 assign keep = (dwid_q != 2'b00);     end
    else             begin : g_bn assign keep = (dwid_q == 2'b10);     end
    assign webb[i]             = wenb & dmask[i];
    assign dmem_rdata[8*i +: 8] = (drd_q & keep) ? qsh[8*i +: 8] : 8'h00;
  end

  assign dmem_resp = dsta;

  // Data response stage plus the offset/width needed to align the load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsta   <= RESP_IDLE;
      drd_q  <= 1'b0;
      doff_q <= 2'b00;
      dwid_q <= 2'b00;
    end else begin
      doff_q <= doff;
      dwid_q <= dmem_width;
      drd_q  <= renb;
      if (!dmem_req)   dsta <= RESP_IDLE;
      else if (dmisal) dsta <= RESP_ERR;
      else             dsta <= RESP_OK;
    end
  end

endmodule

// File: tb/tb_scr1_tcm_port_ctrl.sv
// Bench for scr1_tcm_port_ctrl: a behavioural TCM hangs off ports A/B, and a
// byte-addressed reference model predicts strobes and responses per request.
module tb_scr1_tcm_port_ctrl;
  localparam int AW = 14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_req_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [1:0]  imem_resp;
  logic        dmem_req, dmem_cmd, dmem_req_ack;
  logic [1:0]  dmem_width, dmem_resp;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        rena, renb, wenb;
  logic [AW-1:0] addra, addrb;
  logic [3:0]  webb;
  logic [31:0] datab, qa, qb;

  int nvec = 0;
  int nerr = 0;

  scr1_tcm_port_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_req_ack(imem_req_ack),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req_ack(dmem_req_ack),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .rena(rena), .addra(addra), .qa(qa),
    .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab), .qb(qb)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int w);
    return (w * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  // behavioural TCM: synchronous read, byte-enabled write, read-old on collision
  logic [31:0] tmem [0:(1<<AW)-1];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int w = 0; w < (1<<AW); w++) tmem[w] <= init_word(w);
      mem_ready <= 1'b1;
    end else if (wenb) begin
      for (int k = 0; k < 4; k++)
        if (webb[k]) tmem[addrb][8*k +: 8] <= datab[8*k +: 8];
    end
    qa <= rena ? tmem[addra] : $urandom;
    qb <= renb ? tmem[addrb] : $urandom;
  end

  // reference model: flat byte memory
  logic [7:0] rmem [0:(1<<(AW+2))-1];

  function automatic logic [31:0] rd_bytes(int a, int n);
    logic [31:0] v = 0;
    for (int k = 0; k < n; k++) v = v | (32'(rmem[(a + k) & 16'hFFFF]) << (8*k));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request cycle: drive, check strobes mid-cycle, check response next cycle.
  task automatic cyc(input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dc, input logic [1:0] dw,
                     input logic [31:0] da, input logic [31:0] dwd);
    int sz, off;
    bit dmis, e_rena, e_renb, e_wenb;
    logic [3:0]  e_webb;
    logic [1:0]  e_ires, e_dres;
    logic [31:0] e_irdata, e_drdata;
    sz   = 1 << dw;
    off  = int'(da[1:0]);
    dmis = (dw == 2'd3) || ((off % sz) != 0);
    e_rena   = ir && (ia[1:0] == 2'd0);
    e_ires   = !ir ? 2'd0 : (e_rena ? 2'd1 : 2'd2);
    e_irdata = e_rena ? rd_bytes(int'(ia[15:0]) & 16'hFFFC, 4) : 32'd0;
    e_renb   = dr && !dc && !dmis;
    e_wenb   = dr && dc && !dmis;
    e_webb   = e_wenb ? 4'(((1 << sz) - 1) << off) : 4'd0;
    e_dres   = !dr ? 2'd0 : (dmis ? 2'd2 : 2'd1);
    e_drdata = e_renb ? rd_bytes(int'(da[15:0]), sz) : 32'd0;

    imem_req = ir; imem_addr = ia;
    dmem_req = dr; dmem_cmd = dc; dmem_width = dw; dmem_addr = da; dmem_wdata = dwd;
    #3;
    chk("imem_req_ack", imem_req_ack, ir);
    chk("dmem_req_ack", dmem_req_ack, dr);
    chk("rena", rena, e_rena);
    chk("renb", renb, e_renb);
    chk("wenb", wenb, e_wenb);
    chk("webb", webb, e_webb);
    if (e_rena) chk("addra", addra, ia[15:2]);
    if (e_renb || e_wenb) chk("addrb", addrb, da[15:2]);
    for (int k = 0; k < 4; k++)
      if (e_webb[k]) chk("datab", datab[8*k +: 8], dwd[8*(k-off) +: 8]);
    if (e_wenb)
      for (int k = 0; k < sz; k++) rmem[(int'(da[15:0]) + k) & 16'hFFFF] = dwd[8*k +: 8];

    @(posedge clk); #1;
    chk("imem_resp", imem_resp, e_ires);
    chk("imem_rdata", imem_rdata, e_irdata);
    chk("dmem_resp", dmem_resp, e_dres);
    chk("dmem_rdata", dmem_rdata, e_drdata);
  endtask

  task automatic idle();
    cyc(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int w = 0; w < (1<<AW); w++)
      for (int k = 0; k < 4; k++) rmem[4*w + k] = init_word(w) >> (8*k);

    // reset held with both requests active
    rst_n = 1'b0;
    imem_req = 1; imem_addr = 32'h100;
    dmem_req = 1; dmem_cmd = 0; dmem_width = 2'd2; dmem_addr = 32'h200; dmem_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_resp", imem_resp, 2'd0);
    chk("rst_imem_rdata", imem_rdata, 32'd0);
    chk("rst_dmem_resp", dmem_resp, 2'd0);
    chk("rst_dmem_rdata", dmem_rdata, 32'd0);
    imem_req = 0; dmem_req = 0;
    rst_n = 1'b1;
    idle();

    // aligned fetch of a word placed by a store
    cyc(0, 0, 1, 1, 2'd2, 32'h100, 32'hDEADBEEF);
    cyc(1, 32'h100, 0, 0, 2'd0, 0, 0);
    // byte store into the top lane
    cyc(0, 0, 1, 1, 2'd0, 32'h203, 32'h000000A5);
    // half and byte loads from 0x1234ABCD
    cyc(0, 0, 1, 1, 2'd2, 32'h200, 32'h1234ABCD);
    cyc(0, 0, 1, 0, 2'd1, 32'h202, 0);
    chk("half_load", dmem_rdata, 32'h00001234);
    cyc(0, 0, 1, 0, 2'd0, 32'h201, 0);
    chk("byte_load", dmem_rdata, 32'h000000AB);
    // misaligned data and fetch, memory left untouched
    cyc(0, 0, 1, 0, 2'd2, 32'h102, 0);
    cyc(1, 32'h102, 1, 1, 2'd1, 32'h101, 32'hFFFF);
    cyc(0, 0, 1, 1, 2'd3, 32'h100, 32'h0);
    cyc(0, 0, 1, 0, 2'd2, 32'h100, 0);
    chk("misal_nowrite", dmem_rdata, 32'hDEADBEEF);
    // back-to-back word loads
    cyc(0, 0, 1, 1, 2'd2, 32'h0, 32'h11111111);
    cyc(0, 0, 1, 1, 2'd2, 32'h4, 32'h22222222);
    cyc(0, 0, 1, 1, 2'd2, 32'h8, 32'h33333333);
    cyc(1, 32'h8, 1, 0, 2'd2, 32'h0, 0);
    cyc(1, 32'h4, 1, 0, 2'd2, 32'h4, 0);
    cyc(1, 32'h0, 1, 0, 2'd2, 32'h8, 0);
    // reset asserted while a response is showing and a request is pending
    imem_req = 1; imem_addr = 32'h4;
    dmem_req = 1; dmem_cmd = 0; dmem_width = 2'd2; dmem_addr = 32'h4;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_dmem_resp", dmem_resp, 2'd0);
    chk("midrst_dmem_rdata", dmem_rdata, 32'd0);
    chk("midrst_imem_resp", imem_resp, 2'd0);
    @(posedge clk); #1;
    imem_req = 0; dmem_req = 0;
    rst_n = 1'b1;
    idle();

    // randomized traffic in a small window so fetches and stores collide
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ia, da;
      ia = ($urandom & 32'hFFFF0000) | $urandom_range(0, 255);
      da = ($urandom & 32'hFFFF0000) | $urandom_range(0, 255);
      cyc(1'($urandom), ia, 1'($urandom_range(0, 3) != 0), 1'($urandom),
          2'($urandom), da, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/scr1_tcm_port_ctrl.md
Name: scr1_tcm_port_ctrl

Overview:
- Initiator-side controller for the dual-port TCM: converts the core's instruction and data request/response handshakes into memory-port strobes.
- Port A carries instruction fetch (read-only); port B carries data load/store.
- Handles byte-lane generation, write-data steering, read-data alignment, misalignment errors and the one-cycle synchronous-read latency.
- Sits between the core memory interfaces and the TCM array.

Parameters:
- SCR1_WIDTH, 32, data width in bits; fixed at 32.
- SCR1_SIZE, 32'h00010000, TCM size in bytes; a power of two.
- SCR1_NBYTES, SCR1_WIDTH/8, byte lanes per word.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  in  1  fetch request
- imem_addr  in  32  fetch byte address
- imem_req_ack  out  1  fetch request accepted
- imem_rdata  out  32  fetch data
- imem_resp  out  2  fetch response: 00 IDLE, 01 OKAY, 10 ERR
- dmem_req  in  1  data request
- dmem_cmd  in  1  0 read, 1 write
- dmem_width  in  2  00 byte, 01 half, 10 word, 11 reserved
- dmem_addr  in  32  data byte address
- dmem_wdata  in  32  store data, right-aligned
- dmem_req_ack  out  1  data request accepted
- dmem_rdata  out  32  load data, right-aligned, zero-extended
- dmem_resp  out  2  data response, same encoding as imem_resp
- rena  out  1  port A read enable
- addra  out  $clog2(SCR1_SIZE)-2  port A word address
- qa  in  32  port A read data, valid the cycle after rena
- renb  out  1  port B read enable
- wenb  out  1  port B write enable
- webb  out  4  port B byte enables
- addrb  out  $clog2(SCR1_SIZE)-2  port B word address
- datab  out  32  port B write data
- qb  in  32  port B read data, valid the cycle after renb

Behaviour:
- Reset (async assert, sync release):
  - imem_resp and dmem_resp = 00.
  - imem_rdata and dmem_rdata = 0.
  - Pending-response registers, saved offset and saved width cleared.
  - A response pending when reset asserts is dropped.
- Acceptance: imem_req_ack = imem_req and dmem_req_ack = dmem_req, combinationally. Both ports accept every cycle; no backpressure.
- Latency: a request accepted in cycle N returns its response in cycle N+1, valid for exactly one cycle. Responses are 00 in cycles with no response.
- Back-to-back requests give one response per cycle, in order.
- Address mapping: addra and addrb = addr[$clog2(SCR1_SIZE)-1:2]. Upper bits are ignored; range decode is done upstream.
- Fetch:
  - rena = imem_req & (imem_addr[1:0] == 0).
  - A misaligned fetch is acked and drives rena = 0; the following cycle gives imem_resp = 10 and imem_rdata = 0.
  - An aligned fetch gives imem_resp = 01 and imem_rdata = qa.
- Data misalignment is defined as:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - width 11 (reserved).
  - A misaligned request is acked, drives renb = wenb = 0, and responds 10 next cycle with dmem_rdata = 0. Memory is unmodified.
- Store (aligned):
  - wenb = 1; renb = 0.
  - webb: byte → 1 << off; half → 2'b11 << off; word → 4'hF. Here off = addr[1:0].
  - datab = dmem_wdata << (8*off). Unused lanes are don't-care.
  - Responds 01 next cycle, with dmem_rdata = 0.
- Load (aligned):
  - renb = 1; wenb = 0; webb = 0.
  - off and width are registered at acceptance.
  - Next cycle: dmem_rdata = (qb >> 8*off_q) masked to 8, 16 or 32 bits and zero-extended; dmem_resp = 01.
- With no dmem_req, all port B strobes are 0; with no accepted fetch, rena = 0.
- Simultaneous fetch and data access to the same word are independent. A port A read colliding with a port B write returns the memory's native collision data; this block neither detects nor forwards it.
- Internal state per port is a single response stage: RESP_IDLE / RESP_OK / RESP_ERR, loaded every cycle from the current request.

Test Plan:
- Reset: hold rst_n = 0 with imem_req = dmem_req = 1 → both resp = 00, rdata = 0. Release → the first response appears one cycle after the first accepted request.
- Aligned fetch: imem_addr = 0x100, qa = 0xDEADBEEF next cycle → rena = 1 and addra = 0x40 in N; imem_resp = 01 and imem_rdata = 0xDEADBEEF in N+1.
- Byte store: dmem write, width 00, addr 0x203, wdata 0x000000A5 → webb = 4'b1000, datab[31:24] = 0xA5, addrb = 0x80; dmem_resp = 01 next cycle.
- Half load: addr 0x202, qb = 0x1234ABCD → dmem_rdata = 0x00001234, resp = 01. Then byte load at 0x201 with the same qb → 0x000000AB.
- Misaligned: word load at addr 0x102 → renb = wenb = 0, dmem_resp = 10. Half store at 0x101 → no write, resp = 10.
- Back-to-back and mid-operation reset: word loads to 0x0, 0x4, 0x8 on consecutive cycles → three OKAY responses in order with matching data. Assert rst_n mid-stream → resp forced to 00 immediately, and no stale response after release.
